// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor
// cell with a registered borrow. WIDTH bits take WIDTH RUN cycles.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
//
// Handshake: start is sampled only in IDLE; the accepting edge latches a, b
// and bin. busy is high exactly while state==RUN, done is a one-cycle pulse
// while state==DONE. diff/bout/ovf update only on the edge that enters DONE
// and otherwise hold the previous result. start in RUN/DONE is dropped.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter wide enough to hold WIDTH-1; at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             br;
  logic [CW-1:0]    cnt;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_n;
  logic [WIDTH-1:0] r_next;

  // Full-subtractor cell on the current LSBs; the new bit enters at the MSB
  // so that after WIDTH shifts bit 0 lands at position 0.
  always_comb begin
    ai     = a_sh[0];
    bi     = b_sh[0];
    d      = ai ^ bi ^ br;
    br_n   = (~ai & bi) | (~(ai ^ bi) & br);
    r_next = r_sh >> 1;
    r_next[WIDTH-1] = d;
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            r_sh  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            // Operand sign bits are shifted out during RUN, so keep copies.
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_n;
          r_sh <= r_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff  <= r_next;
            bout  <= br_n;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_msb != b_msb) && (r_next[WIDTH-1] != a_msb);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors for serial_subtractor (WIDTH=8).
// Driver tasks push the expected {ovf,bout,diff} into exp_q when a request
// is issued; the monitor pops and compares on every done pulse.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
  logic         last_ovf;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_count = 0;
  int last_done_cyc = -100;
  int prev_done_cyc = -100;

  logic [W+1:0] exp_q[$];
  logic [W-1:0] last_diff;
  logic         last_bout;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .bin(bin),
    .busy(busy),
    .done(done),
    .diff(diff),
    .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each done pulse against the oldest expected result
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      done_count++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_done_queue_entries", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("diff", 32'(diff), 32'(e[W-1:0]));
        check("bout", 32'(bout), 32'(e[W]));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(e[W+1]));
`endif
      end
    end
  end

  task automatic check_held(input string tag);
    check({tag, "_diff_held"}, 32'(diff), 32'(last_diff));
    check({tag, "_bout_held"}, 32'(bout), 32'(last_bout));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf_held"}, 32'(ovf), 32'(last_ovf));
`endif
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input bit push, input logic [W-1:0] e_diff, input logic e_bout,
                       input logic e_ovf);
    @(negedge clk);
    a = ia;
    b = ib;
    bin = ibin;
    start = 1'b1;
    if (push) exp_q.push_back({e_ovf, e_bout, e_diff});
  endtask

  // Follow one accepted operation: busy window, done pulse, return to IDLE.
  // With hold set, start stays high and operands are scrambled during RUN.
  task automatic window(input bit hold, input logic [W-1:0] e_diff, input logic e_bout,
                        input logic e_ovf);
    @(posedge clk);  // E0
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (!hold) begin
        start = 1'b0;
      end else begin
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        bin = 1'($urandom_range(0, 1));
      end
      check("busy_in_run", 32'(busy), 32'd1);
      check("done_in_run", 32'(done), 32'd0);
      check_held("run");
    end
    @(negedge clk);  // after E(W)
    check("busy_at_done", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    if (!hold) start = 1'b0;
    last_diff = e_diff;
    last_bout = e_bout;
`ifdef SERIAL_SUB_OVF_EN
    last_ovf = e_ovf;
`endif
    @(negedge clk);  // after E(W+1): DONE ignored any start
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check_held("idle");
  endtask

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                    input logic [W-1:0] e_diff, input logic e_bout, input logic e_ovf,
                    input bit hold);
    issue(ia, ib, ibin, 1'b1, e_diff, e_bout, e_ovf);
    window(hold, e_diff, e_bout, e_ovf);
  endtask

  initial begin
    int dc;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    last_diff = '0;
    last_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    last_ovf = 1'b0;
`endif
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check_held("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic, underflow, borrow-in and overflow vectors
    op(8'd100, 8'd37, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0);
    op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    op(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
    op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
    op(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    op(8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0);

    // Start held high and operands changed during RUN: one result only
    op(8'd100, 8'd37, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b1);

    // Back-to-back: start held high across two acceptances
    dc = done_count;
    issue(8'd100, 8'd37, 1'b0, 1'b1, 8'h3F, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'h3F});
    @(posedge clk);  // E0
    for (int k = 0; k < 10; k++) @(negedge clk);  // through E9
    @(negedge clk);  // after E10, second op running
    start = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    check("b2b_done_count", 32'(done_count - dc), 32'd2);
    check("b2b_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd10);
    last_diff = 8'h3F;
    last_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    last_ovf = 1'b0;
`endif

    // Abort: asynchronous reset in the middle of RUN
    issue(8'h12, 8'h34, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);  // E0
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    last_diff = '0;
    last_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    last_ovf = 1'b0;
`endif
    check_held("abort");
    dc = done_count;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_count), 32'(dc));
    check_held("after_abort");

    op(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
